// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives open-drain clk/data enables and reports ACK/timeout per byte.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [20:0] cnt_q, cnt_d;
  logic        drv_q, drv_d;
  logic        smp_q, smp_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fe;
  logic running;
  logic [3:0] nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe  = clk_prev_q & ~clk_s2_q;
  assign nxt = bitcnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    drv_d    = drv_q;
    smp_d    = smp_q;
    done_d   = 1'b0;
    ack_d    = ack_q;
    err_d    = err_q;
    running  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = 4'd0;
          cnt_d    = '0;
          ack_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      S_REQ: begin
        running = 1'b1;
        if (fe) begin
          drv_d    = ~frame_q[0];
          bitcnt_d = 4'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        running = 1'b1;
        if (fe) begin
          bitcnt_d = nxt;
          drv_d    = ~frame_q[nxt];
          if (nxt == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        running = 1'b1;
        if (fe) begin
          smp_d   = ~dat_s2_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        running = 1'b1;
        if (clk_s2_q && dat_s2_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ack_d   = smp_q;
          err_d   = ~smp_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // watchdog shares the counter with the inhibit timer
    if (running) begin
      if (fe) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST && state_d == state_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ack_d   = 1'b0;
        err_d   = 1'b1;
        drv_d   = 1'b0;
      end else begin
        cnt_d = cnt_q + 21'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      drv_q    <= 1'b0;
      smp_q    <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      drv_q    <= drv_d;
      smp_q    <= smp_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign rx_inhibit  = busy;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign error       = err_q;
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = ((state_q == S_INHIBIT) && (cnt_q == INH_LAST))
                     | (state_q == S_REQ)
                     | (((state_q == S_SEND) || (state_q == S_ACK)) && drv_q);

endmodule
